// File: rtl/rnn_ram_pkg.sv
// Shared types for the RNN parameter/state RAM read sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rnn_ram_pkg;

   localparam int RAMSIZE = 512;
   localparam int ADDR_W  = 9;
   localparam int DATA_W  = 32;

   // Sweep length / issue counter: one bit wider than an address so that
   // a full-RAM sweep (count == RAMSIZE) is representable.
   typedef logic [ADDR_W:0] cnt_t;

   // One output beat: the five bank words at a single index.
   typedef struct packed {
      logic [DATA_W-1:0] w;
      logic [DATA_W-1:0] h;
      logic [DATA_W-1:0] u;
      logic [DATA_W-1:0] x;
      logic [DATA_W-1:0] v;
      logic [ADDR_W-1:0] index;
      logic              last;
   } tuple_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_DRAIN,
      ST_DONE
   } state_t;

endpackage

// File: rtl/rnn_tuple_fifo.sv
// Synchronous FIFO of DEPTH tuples; push and pop may occur in the same cycle.
// Latency: a pushed tuple is visible at pop_dat the cycle after the push.
// Backpressure: push is dropped only when full with no pop; pop when empty is ignored.
// Ports: clk/reset, push/push_dat in, pop in, pop_dat (head) out, count/full/empty out.
module rnn_tuple_fifo
   import rnn_ram_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  tuple_t           push_dat,
   input  logic             pop,
   output tuple_t           pop_dat,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   tuple_t           mem_q [DEPTH];
   logic             push_ok;
   logic             pop_ok;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      pop_ok   = pop && (count_q != '0);
      // A full FIFO still accepts a push when the head leaves in the same cycle.
      push_ok  = push && ((count_q != CNT_W'(DEPTH)) || pop_ok);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = ptr_next(wr_ptr_q);
      if (pop_ok)  rd_ptr_d = ptr_next(rd_ptr_q);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: nothing is read from it while count is zero.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_dat;
   end

   assign pop_dat = mem_q[rd_ptr_q];
   assign count   = count_q;
   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);

endmodule

// File: rtl/rnn_ram_reader.sv
// Sweeps COUNT indices from BASE over the W/H/U/X/V banks and streams tuples out.
// Latency: start in cycle 0 -> readport=base in cycle 1 -> first out_valid in cycle 3; 1 tuple/cycle.
// Backpressure: reads issue only while fifo_count + reads in flight < FIFO_DEPTH; out_valid holds until accepted.
// Ports: clk/reset; start/base/count command; busy/done status; readport + readW..V RAM side;
//        out_valid/out_ready handshake with outW..V, out_index, out_last.
module rnn_ram_reader
   import rnn_ram_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base,
   input  logic [ADDR_W:0]   count,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] readport,
   input  logic [DATA_W-1:0] readW,
   input  logic [DATA_W-1:0] readH,
   input  logic [DATA_W-1:0] readU,
   input  logic [DATA_W-1:0] readX,
   input  logic [DATA_W-1:0] readV,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] outW,
   output logic [DATA_W-1:0] outH,
   output logic [DATA_W-1:0] outU,
   output logic [DATA_W-1:0] outX,
   output logic [DATA_W-1:0] outV,
   output logic [ADDR_W-1:0] out_index,
   output logic              out_last
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   cnt_t              count_q, count_d;
   cnt_t              issued_q, issued_d;
   logic [ADDR_W-1:0] readport_q, readport_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   // In-flight tracker: stage 1 = address registered on readport,
   // stage 2 = RAM data present on readW..readV.
   logic              s1_vld_q, s1_vld_d;
   logic [ADDR_W-1:0] s1_idx_q, s1_idx_d;
   logic              s1_last_q, s1_last_d;
   logic              s2_vld_q, s2_vld_d;
   logic [ADDR_W-1:0] s2_idx_q, s2_idx_d;
   logic              s2_last_q, s2_last_d;

   tuple_t            push_dat;
   tuple_t            head;
   tuple_t            out_t;
   logic              pop;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CNT_W:0]    occupancy;
   logic              credit_ok;
   logic [ADDR_W-1:0] next_addr;
   logic              issue_last;

   always_comb begin
      occupancy  = {1'b0, fifo_count} + {{CNT_W{1'b0}}, s1_vld_q} + {{CNT_W{1'b0}}, s2_vld_q};
      credit_ok  = !fifo_full && (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
      // RAMSIZE is a power of two, so truncation to ADDR_W is the modulo wrap.
      next_addr  = base_q + issued_q[ADDR_W-1:0];
      issue_last = (issued_q == count_q - cnt_t'(1));
      pop        = !fifo_empty && out_ready;

      push_dat.w     = readW;
      push_dat.h     = readH;
      push_dat.u     = readU;
      push_dat.x     = readX;
      push_dat.v     = readV;
      push_dat.index = s2_idx_q;
      push_dat.last  = s2_last_q;
   end

   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      count_d    = count_q;
      issued_d   = issued_q;
      readport_d = readport_q;
      s1_vld_d   = 1'b0;
      s1_idx_d   = s1_idx_q;
      s1_last_d  = s1_last_q;
      s2_vld_d   = s1_vld_q;
      s2_idx_d   = s1_idx_q;
      s2_last_d  = s1_last_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               base_d  = base;
               count_d = count;
               if (count == '0) begin
                  state_d = ST_DONE;
               end else begin
                  // First read issues straight from the command so readport
                  // carries base in the cycle after start.
                  readport_d = base;
                  s1_vld_d   = 1'b1;
                  s1_idx_d   = base;
                  s1_last_d  = (count == cnt_t'(1));
                  issued_d   = cnt_t'(1);
                  state_d    = (count == cnt_t'(1)) ? ST_DRAIN : ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            if (credit_ok) begin
               readport_d = next_addr;
               s1_vld_d   = 1'b1;
               s1_idx_d   = next_addr;
               s1_last_d  = issue_last;
               issued_d   = issued_q + cnt_t'(1);
               if (issue_last) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (pop && head.last) state_d = ST_DONE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         base_q     <= '0;
         count_q    <= '0;
         issued_q   <= '0;
         readport_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         s1_vld_q   <= 1'b0;
         s1_idx_q   <= '0;
         s1_last_q  <= 1'b0;
         s2_vld_q   <= 1'b0;
         s2_idx_q   <= '0;
         s2_last_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         count_q    <= count_d;
         issued_q   <= issued_d;
         readport_q <= readport_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         s1_vld_q   <= s1_vld_d;
         s1_idx_q   <= s1_idx_d;
         s1_last_q  <= s1_last_d;
         s2_vld_q   <= s2_vld_d;
         s2_idx_q   <= s2_idx_d;
         s2_last_q  <= s2_last_d;
      end
   end

   rnn_tuple_fifo #(
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (s2_vld_q),
      .push_dat (push_dat),
      .pop      (pop),
      .pop_dat  (head),
      .count    (fifo_count),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   // Data outputs read as zero whenever nothing is presented.
   assign out_t     = fifo_empty ? '0 : head;
   assign out_valid = !fifo_empty;
   assign outW      = out_t.w;
   assign outH      = out_t.h;
   assign outU      = out_t.u;
   assign outX      = out_t.x;
   assign outV      = out_t.v;
   assign out_index = out_t.index;
   assign out_last  = out_t.last;
   assign readport  = readport_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_rnn_ram_reader.sv
// Bench for rnn_ram_reader: RAM model, sweep-level scoreboard, directed sweeps.
// Latency: checks start->first beat = 3 cycles and done one cycle after the last beat.
// Backpressure: exercised with out_ready toggling every cycle.
module tb_rnn_ram_reader;
   import rnn_ram_pkg::*;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [ADDR_W-1:0] base;
   logic [ADDR_W:0]   count;
   logic              busy, done;
   logic [ADDR_W-1:0] readport;
   logic [DATA_W-1:0] readW, readH, readU, readX, readV;
   logic              out_valid, out_ready;
   logic [DATA_W-1:0] outW, outH, outU, outX, outV;
   logic [ADDR_W-1:0] out_index;
   logic              out_last;

   always #5 clk = ~clk;

   rnn_ram_reader #(.FIFO_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .start(start), .base(base), .count(count),
      .busy(busy), .done(done), .readport(readport),
      .readW(readW), .readH(readH), .readU(readU), .readX(readX), .readV(readV),
      .out_valid(out_valid), .out_ready(out_ready),
      .outW(outW), .outH(outH), .outU(outU), .outX(outX), .outV(outV),
      .out_index(out_index), .out_last(out_last)
   );

   // RAM model with a one-cycle registered read.
   logic [DATA_W-1:0] ram_w [RAMSIZE];
   logic [DATA_W-1:0] ram_h [RAMSIZE];
   logic [DATA_W-1:0] ram_u [RAMSIZE];
   logic [DATA_W-1:0] ram_x [RAMSIZE];
   logic [DATA_W-1:0] ram_v [RAMSIZE];

   initial begin
      for (int i = 0; i < RAMSIZE; i++) begin
         ram_w[i] = DATA_W'(i + 100);
         ram_h[i] = DATA_W'(i + 200);
         ram_u[i] = DATA_W'(i + 300);
         ram_x[i] = DATA_W'(i + 400);
         ram_v[i] = DATA_W'(i + 500);
      end
   end

   always @(posedge clk) begin
      readW <= ram_w[readport];
      readH <= ram_h[readport];
      readU <= ram_u[readport];
      readX <= ram_x[readport];
      readV <= ram_v[readport];
   end

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Behavioural model: a sweep is just the list of indices (base+k) mod RAMSIZE.
   typedef struct {
      int idx;
      bit last;
   } exp_t;
   exp_t exp_q[$];

   int  t0, sweep_beats, sweep_done, done_cnt, done_cyc;
   int  first_beat_cyc, last_beat_cyc;
   bit  busy_seen;
   int  got_idx[$];
   int  got_x[$];
   int  got_w[$];
   bit  stall_prev = 1'b0;
   logic [ADDR_W-1:0] prev_idx;
   logic [DATA_W-1:0] prev_w;
   bit  ready_mode = 1'b0;

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (ready_mode) out_ready = ~out_ready;
         else            out_ready = 1'b1;
      end
   end

   // Compare process: every accepted beat is matched against the model.
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         stall_prev = 1'b0;
      end else begin
         if (busy) busy_seen = 1'b1;
         if (done) begin
            done_cnt++;
            sweep_done++;
            done_cyc = cyc;
         end
         if (stall_prev) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_index", out_index, prev_idx);
            chk("stall_w", outW, prev_w);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: got index %0d, expected no beat", out_index);
            end else begin
               e = exp_q.pop_front();
               chk("beat_index", out_index, e.idx);
               chk("beat_w", outW, e.idx + 100);
               chk("beat_h", outH, e.idx + 200);
               chk("beat_u", outU, e.idx + 300);
               chk("beat_x", outX, e.idx + 400);
               chk("beat_v", outV, e.idx + 500);
               chk("beat_last", out_last, e.last);
            end
            if (sweep_beats == 0) first_beat_cyc = cyc;
            if (out_last) last_beat_cyc = cyc;
            sweep_beats++;
            got_idx.push_back(int'(out_index));
            got_x.push_back(int'(outX));
            got_w.push_back(int'(outW));
         end
         stall_prev = out_valid && !out_ready;
         prev_idx   = out_index;
         prev_w     = outW;
      end
   end

   task automatic start_sweep(input int b, input int c, input bit check_rp);
      @(posedge clk);
      #1;
      start       = 1'b1;
      base        = ADDR_W'(b);
      count       = (ADDR_W + 1)'(c);
      t0          = cyc;
      sweep_beats = 0;
      sweep_done  = 0;
      busy_seen   = 1'b0;
      got_idx.delete();
      got_x.delete();
      got_w.delete();
      for (int k = 0; k < c; k++) exp_q.push_back('{idx: (b + k) % RAMSIZE, last: (k == c - 1)});
      @(posedge clk);
      #1;
      start = 1'b0;
      if (check_rp) chk("readport_first", readport, b);
   endtask

   task automatic wait_done(input int budget, input string name);
      int n = 0;
      while (sweep_done == 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (sweep_done == 0) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got no done in %0d cycles, expected done", name, budget);
      end else begin
         chk({name, "_busy_in_done"}, busy, 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion by 200000, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int d0;
      reset = 1'b1;
      start = 1'b0;
      base  = '0;
      count = '0;
      done_cnt = 0;
      sweep_done = 0;
      sweep_beats = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_readport", readport, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_outW", outW, 0);
      chk("rst_out_index", out_index, 0);
      chk("rst_out_last", out_last, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // 1: basic sweep, latency pinned by hand.
      start_sweep(0, 4, 1);
      wait_done(40, "t1");
      chk("t1_first_beat_cycle", first_beat_cyc - t0, 3);
      chk("t1_last_beat_cycle", last_beat_cyc - t0, 6);
      chk("t1_done_cycle", done_cyc - t0, 7);
      chk("t1_beats", sweep_beats, 4);
      chk("t1_w0", got_w[0], 100);
      chk("t1_w3", got_w[3], 103);
      chk("t1_model_empty", exp_q.size(), 0);

      // 2: address wrap.
      start_sweep(510, 4, 1);
      wait_done(40, "t2");
      chk("t2_beats", sweep_beats, 4);
      chk("t2_idx0", got_idx[0], 510);
      chk("t2_idx1", got_idx[1], 511);
      chk("t2_idx2", got_idx[2], 0);
      chk("t2_idx3", got_idx[3], 1);
      chk("t2_x0", got_x[0], 910);
      chk("t2_x1", got_x[1], 911);
      chk("t2_x2", got_x[2], 400);
      chk("t2_x3", got_x[3], 401);

      // 3: backpressure with ready toggling every cycle.
      ready_mode = 1'b1;
      start_sweep(8, 8, 1);
      wait_done(100, "t3");
      ready_mode = 1'b0;
      chk("t3_beats", sweep_beats, 8);
      for (int k = 0; k < 8 && k < got_idx.size(); k++) chk("t3_order", got_idx[k], 8 + k);
      chk("t3_model_empty", exp_q.size(), 0);

      // 4: empty sweep.
      start_sweep(3, 0, 0);
      wait_done(10, "t4");
      chk("t4_done_cycle", done_cyc - t0, 1);
      repeat (4) @(negedge clk);
      chk("t4_beats", sweep_beats, 0);
      chk("t4_busy_seen", busy_seen, 0);
      chk("t4_done_once", sweep_done, 1);

      // 5: reset in the middle of a sweep, then a fresh sweep.
      start_sweep(20, 10, 1);
      n = 0;
      while (sweep_beats < 2 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("t5_two_beats", sweep_beats, 2);
      @(posedge clk);
      #1;
      reset = 1'b1;
      exp_q.delete();
      d0 = done_cnt;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("t5_out_valid", out_valid, 0);
      chk("t5_busy", busy, 0);
      chk("t5_done", done, 0);
      chk("t5_readport", readport, 0);
      repeat (5) @(negedge clk);
      chk("t5_no_done", done_cnt, d0);
      start_sweep(5, 2, 1);
      wait_done(40, "t5b");
      chk("t5b_beats", sweep_beats, 2);
      chk("t5b_idx0", got_idx[0], 5);
      chk("t5b_idx1", got_idx[1], 6);

      // 6: full-RAM sweep with an ignored start mid-way.
      start_sweep(0, 512, 1);
      repeat (10) @(posedge clk);
      #1;
      start = 1'b1;
      base  = ADDR_W'(100);
      count = (ADDR_W + 1)'(3);
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("t6_busy_mid", busy, 1);
      wait_done(700, "t6");
      repeat (10) @(negedge clk);
      chk("t6_beats", sweep_beats, 512);
      chk("t6_done_once", sweep_done, 1);
      chk("t6_idx_first", got_idx[0], 0);
      chk("t6_idx_last", got_idx[511], 511);
      chk("t6_model_empty", exp_q.size(), 0);
      chk("t6_idle_busy", busy, 0);
      chk("t6_idle_valid", out_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
